// File: rtl/dmc_pkg.sv
// Shared types for the data memory controller: access size codes, FSM states
// and the alignment rule applied when a request is accepted.
package dmc_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  // True when the access must be rejected without touching memory.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = addr_lo[0];
      SZ_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side request/response channel of the data memory controller.
// master = core, slave = controller.
interface dmc_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmc_lane_align.sv
// Little-endian lane handling: extract/extend a byte or half from a memory word
// for loads, and splice store data into the old word for sub-word stores.
module dmc_lane_align
  import dmc_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_ofs;
  logic [4:0]  half_ofs;

  assign byte_ofs = {addr_lo, 3'b000};
  assign half_ofs = {addr_lo[1], 4'b0000};
  assign byte_sel = rd_word[byte_ofs +: 8];
  assign half_sel = rd_word[half_ofs +: 16];

  always_comb begin
    ld_data = rd_word;
    st_word = rd_word;
    case (size)
      SZ_B: begin
        ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        st_word[byte_ofs +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        st_word[half_ofs +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = rd_word;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the core data port and a word-only synchronous RAM.
// Optional DMC_ERRCNT_EN adds a saturating 16-bit err_count output.
module data_mem_ctrl
  import dmc_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmc_req_if.slave          core,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
`ifdef DMC_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  // state   | meaning
  // IDLE    | req_ready high, waiting for a request
  // RD      | waiting MEM_LATENCY cycles for read data (load or RMW old word)
  // WR      | mem_we high for one cycle
  // RESP    | rsp_valid pulse, back to IDLE next cycle

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic               uns_q, uns_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        ld_data;
  logic [31:0]        st_word;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^core.req_addr[31:ADDR_W+2];

  dmc_lane_align u_align (
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rd_word     (mem_dout),
    .wdata       (wdata_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          we_d      = core.req_we;
          size_d    = core.req_size;
          addr_lo_d = core.req_addr[1:0];
          uns_d     = core.req_unsigned;
          wdata_d   = core.req_wdata;
          ready_d   = 1'b0;
          if (access_err(core.req_size, core.req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            mem_addr_d = core.req_addr[ADDR_W+1:2];
            if (core.req_we && core.req_size == SZ_W) begin
              state_d  = ST_WR;
              mem_we_d = 1'b1;
            end else begin
              state_d = ST_RD;
              cnt_d   = CNT_W'(MEM_LATENCY);
            end
          end
        end
      end
      ST_RD: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The RMW write cycle coincides with the read data becoming valid;
        // the merged word is formed combinationally from mem_dout in WR.
        if (we_q) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_WR;
            mem_we_d = 1'b1;
            cnt_d    = '0;
          end
        end else if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_data;
          cnt_d       = '0;
        end
      end
      ST_WR: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        ready_d     = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_lo_q   <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_din        = (state_q == ST_WR && size_q != SZ_W) ? st_word : wdata_q;
  assign core.req_ready = ready_q;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rsp_rdata_q;
  assign core.rsp_err   = rsp_err_q;

`ifdef DMC_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rsp_valid_q && rsp_err_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: dut0 with MEM_LATENCY=1, dut1 with MEM_LATENCY=3, each with its own RAM model.
module tb_data_mem_ctrl;
  import dmc_pkg::*;

  logic clk;
  logic rst;

  logic        t_we;
  logic [31:0] t_addr;
  logic [1:0]  t_size;
  logic        t_uns;
  logic [31:0] t_wdata;
  logic        v0, v1;
  logic        cur_sel;

  logic        mem_we0, mem_we1;
  logic [8:0]  mem_addr0, mem_addr1;
  logic [31:0] mem_din0, mem_din1;
  logic [31:0] dout0;
  logic [31:0] p1a, p1b, p1c;

  logic        pl_en0, pl_en1;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  logic [31:0] ram0 [0:511];
  logic [31:0] ram1 [0:511];

  int pass_cnt;
  int total_cnt;

`ifdef DMC_ERRCNT_EN
  logic [15:0] err_count0, err_count1;
`endif

  dmc_req_if if0 ();
  dmc_req_if if1 ();

  assign if0.req_valid    = v0;
  assign if0.req_we       = t_we;
  assign if0.req_addr     = t_addr;
  assign if0.req_size     = t_size;
  assign if0.req_unsigned = t_uns;
  assign if0.req_wdata    = t_wdata;
  assign if1.req_valid    = v1;
  assign if1.req_we       = t_we;
  assign if1.req_addr     = t_addr;
  assign if1.req_size     = t_size;
  assign if1.req_unsigned = t_uns;
  assign if1.req_wdata    = t_wdata;

  data_mem_ctrl #(.ADDR_W(9), .MEM_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .core(if0.slave),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_dout(dout0)
`ifdef DMC_ERRCNT_EN
    , .err_count(err_count0)
`endif
  );

  data_mem_ctrl #(.ADDR_W(9), .MEM_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst), .core(if1.slave),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(p1c)
`ifdef DMC_ERRCNT_EN
    , .err_count(err_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en0) ram0[pl_addr] <= pl_data;
    else if (mem_we0) ram0[mem_addr0] <= mem_din0;
    dout0 <= ram0[mem_addr0];
  end

  always @(posedge clk) begin
    if (pl_en1) ram1[pl_addr] <= pl_data;
    else if (mem_we1) ram1[mem_addr1] <= mem_din1;
    p1a <= ram1[mem_addr1];
    p1b <= p1a;
    p1c <= p1b;
  end

  logic        s_ready, s_rv, s_err, s_we;
  logic [31:0] s_rdata, s_din;
  assign s_ready = cur_sel ? if1.req_ready : if0.req_ready;
  assign s_rv    = cur_sel ? if1.rsp_valid : if0.rsp_valid;
  assign s_err   = cur_sel ? if1.rsp_err   : if0.rsp_err;
  assign s_rdata = cur_sel ? if1.rsp_rdata : if0.rsp_rdata;
  assign s_we    = cur_sel ? mem_we1       : mem_we0;
  assign s_din   = cur_sel ? mem_din1      : mem_din0;

  task automatic preload(input logic sel, input logic [8:0] waddr, input logic [31:0] data);
    @(negedge clk);
    pl_addr = waddr;
    pl_data = data;
    if (sel) pl_en1 = 1'b1; else pl_en0 = 1'b1;
    @(negedge clk);
    pl_en0 = 1'b0;
    pl_en1 = 1'b0;
  endtask

  // Drives one request at cycle 0 and records what happens up to the response cycle.
  task automatic issue(input logic sel, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       output int rcyc, output logic [31:0] rdata, output logic err,
                       output int wecnt, output int wecyc, output logic [31:0] wedin,
                       output logic rdy0, output logic rv0, output int rdybad);
    @(negedge clk);
    cur_sel = sel;
    #1;
    rdy0 = s_ready;
    rv0  = s_rv;
    t_we = we; t_addr = addr; t_size = size; t_uns = uns; t_wdata = wdata;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    rcyc = -1; rdata = '0; err = 1'b0; wecnt = 0; wecyc = -1; wedin = '0; rdybad = 0;
    for (int c = 1; c <= 20 && rcyc < 0; c++) begin
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b0;
      if (s_we) begin wecnt++; wecyc = c; wedin = s_din; end
      if (s_ready) rdybad++;
      if (s_rv) begin rcyc = c; rdata = s_rdata; err = s_err; end
    end
  endtask

  int rc, wc, wy, rb;
  logic [31:0] rd, wd;
  logic er, r0, q0;

  task automatic test_reset();
    total_cnt++; if (if0.req_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", if0.req_ready); else pass_cnt++;
    total_cnt++; if (if0.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", if0.rsp_valid); else pass_cnt++;
    total_cnt++; if (if0.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", if0.rsp_rdata); else pass_cnt++;
    total_cnt++; if (if0.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %0b want 0", if0.rsp_err); else pass_cnt++;
    total_cnt++; if (mem_we0 !== 1'b0) $display("FAIL reset_mem_we got %0b want 0", mem_we0); else pass_cnt++;
    total_cnt++; if (mem_addr0 !== 9'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr0); else pass_cnt++;
    total_cnt++; if (mem_din0 !== 32'h0) $display("FAIL reset_mem_din got %h want 0", mem_din0); else pass_cnt++;
    total_cnt++; if (if1.req_ready !== 1'b1) $display("FAIL reset_ready1 got %0b want 1", if1.req_ready); else pass_cnt++;
`ifdef DMC_ERRCNT_EN
    total_cnt++; if (err_count0 !== 16'h0) $display("FAIL reset_err_count got %0d want 0", err_count0); else pass_cnt++;
`endif
  endtask

  task automatic test_load();
    logic [31:0] exp_d [6];
    logic [31:0] addrs [6];
    logic [1:0]  sizes [6];
    logic        unss  [6];
    exp_d = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFAABB, 32'h00008899, 32'hFFFFFF88, 32'h000000BB};
    addrs = '{32'h11, 32'h11, 32'h10, 32'h12, 32'h13, 32'h10};
    sizes = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_B, SZ_B};
    unss  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    preload(1'b0, 9'd4, 32'h8899AABB);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 1'b0, addrs[i], sizes[i], unss[i], 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
      total_cnt++; if (rc !== 3) $display("FAIL load%0d_cycle got %0d want 3", i, rc); else pass_cnt++;
      total_cnt++; if (rd !== exp_d[i]) $display("FAIL load%0d_rdata got %h want %h", i, rd, exp_d[i]); else pass_cnt++;
      total_cnt++; if (er !== 1'b0 || wc !== 0 || rb !== 0)
        $display("FAIL load%0d_side err=%0b we_cnt=%0d ready_hi=%0d want 0/0/0", i, er, wc, rb); else pass_cnt++;
    end
  endtask

  task automatic test_store_sub();
    issue(1'b0, 1'b1, 32'h12, SZ_H, 1'b0, 32'h00001234, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (wc !== 1 || wy !== 2) $display("FAIL sh_we count=%0d cycle=%0d want 1/2", wc, wy); else pass_cnt++;
    total_cnt++; if (wd !== 32'h1234AABB) $display("FAIL sh_din got %h want 1234aabb", wd); else pass_cnt++;
    total_cnt++; if (rc !== 3 || er !== 1'b0 || rd !== 32'h0) $display("FAIL sh_rsp cyc=%0d err=%0b rdata=%h want 3/0/0", rc, er, rd); else pass_cnt++;
    issue(1'b0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (rc !== 3 || rd !== 32'h1234AABB) $display("FAIL sh_readback cyc=%0d rdata=%h want 3/1234aabb", rc, rd); else pass_cnt++;
    issue(1'b0, 1'b1, 32'h11, SZ_B, 1'b0, 32'hFFFFFF55, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (wc !== 1 || wy !== 2 || wd !== 32'h123455BB) $display("FAIL sb_din cnt=%0d cyc=%0d din=%h want 1/2/123455bb", wc, wy, wd); else pass_cnt++;
    total_cnt++; if (ram0[4] !== 32'h123455BB) $display("FAIL sb_mem got %h want 123455bb", ram0[4]); else pass_cnt++;
  endtask

  task automatic test_store_word();
    issue(1'b0, 1'b1, 32'h20, SZ_W, 1'b0, 32'hDEADBEEF, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (wc !== 1 || wy !== 1) $display("FAIL sw_we count=%0d cycle=%0d want 1/1", wc, wy); else pass_cnt++;
    total_cnt++; if (wd !== 32'hDEADBEEF) $display("FAIL sw_din got %h want deadbeef", wd); else pass_cnt++;
    total_cnt++; if (rc !== 2 || er !== 1'b0) $display("FAIL sw_rsp cyc=%0d err=%0b want 2/0", rc, er); else pass_cnt++;
    total_cnt++; if (ram0[8] !== 32'hDEADBEEF) $display("FAIL sw_mem got %h want deadbeef", ram0[8]); else pass_cnt++;
    // 0x820 aliases word 8 once the upper address bits are dropped
    issue(1'b0, 1'b1, 32'h00000820, SZ_W, 1'b0, 32'h0BADF00D, rc, rd, er, wc, wy, wd, r0, q0, rb);
    issue(1'b0, 1'b0, 32'h20, SZ_W, 1'b0, 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (rd !== 32'h0BADF00D) $display("FAIL sw_wrap got %h want 0badf00d", rd); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs = '{32'h13, 32'h11, 32'h10};
    sizes = '{SZ_W, SZ_H, SZ_ILL};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, i[0], addrs[i], sizes[i], 1'b0, 32'hFFFFFFFF, rc, rd, er, wc, wy, wd, r0, q0, rb);
      total_cnt++; if (rc !== 1 || er !== 1'b1) $display("FAIL err%0d_rsp cyc=%0d err=%0b want 1/1", i, rc, er); else pass_cnt++;
      total_cnt++; if (rd !== 32'h0 || wc !== 0) $display("FAIL err%0d_side rdata=%h we_cnt=%0d want 0/0", i, rd, wc); else pass_cnt++;
    end
    issue(1'b1, 1'b0, 32'h13, SZ_H, 1'b0, 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (rc !== 1 || er !== 1'b1 || wc !== 0) $display("FAIL err_lat3 cyc=%0d err=%0b we_cnt=%0d want 1/1/0", rc, er, wc); else pass_cnt++;
    @(negedge clk);
`ifdef DMC_ERRCNT_EN
    total_cnt++; if (err_count0 !== 16'd3) $display("FAIL err_count got %0d want 3", err_count0); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_abort();
    int rv_seen;
    preload(1'b0, 9'd4, 32'h8899AABB);
    // abort in RD
    @(negedge clk);
    cur_sel = 1'b0;
    t_we = 1'b1; t_addr = 32'h10; t_size = SZ_B; t_uns = 1'b0; t_wdata = 32'h55; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    rst = 1'b0;
    #1;
    total_cnt++; if (mem_we0 !== 1'b0) $display("FAIL abort_rd_we got %0b want 0", mem_we0); else pass_cnt++;
    rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if0.rsp_valid) rv_seen++;
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if0.rsp_valid || mem_we0) rv_seen++;
    end
    total_cnt++; if (rv_seen !== 0) $display("FAIL abort_rd_activity got %0d want 0", rv_seen); else pass_cnt++;
    total_cnt++; if (if0.req_ready !== 1'b1) $display("FAIL abort_rd_ready got %0b want 1", if0.req_ready); else pass_cnt++;
    total_cnt++; if (ram0[4] !== 32'h8899AABB) $display("FAIL abort_rd_mem got %h want 8899aabb", ram0[4]); else pass_cnt++;
    // abort in WR: strobe must fall before the write edge
    t_we = 1'b1; t_addr = 32'h10; t_size = SZ_B; t_wdata = 32'h55; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    total_cnt++; if (mem_we0 !== 1'b1) $display("FAIL abort_wr_pre got %0b want 1", mem_we0); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (mem_we0 !== 1'b0) $display("FAIL abort_wr_we got %0b want 0", mem_we0); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (ram0[4] !== 32'h8899AABB || if0.rsp_valid !== 1'b0)
      $display("FAIL abort_wr_mem got %h rv=%0b want 8899aabb/0", ram0[4], if0.rsp_valid); else pass_cnt++;
`ifdef DMC_ERRCNT_EN
    total_cnt++; if (err_count0 !== 16'd0) $display("FAIL abort_err_count got %0d want 0", err_count0); else pass_cnt++;
`endif
  endtask

  task automatic test_latency3();
    preload(1'b1, 9'd4, 32'h8899AABB);
    issue(1'b1, 1'b0, 32'h12, SZ_H, 1'b1, 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (rc !== 5 || rd !== 32'h00008899) $display("FAIL lat3_lhu cyc=%0d rdata=%h want 5/00008899", rc, rd); else pass_cnt++;
    total_cnt++; if (rb !== 0) $display("FAIL lat3_ready_hi got %0d want 0", rb); else pass_cnt++;
    issue(1'b1, 1'b1, 32'h11, SZ_B, 1'b0, 32'h00000055, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (wc !== 1 || wy !== 4 || wd !== 32'h889955BB)
      $display("FAIL lat3_sb cnt=%0d cyc=%0d din=%h want 1/4/889955bb", wc, wy, wd); else pass_cnt++;
    total_cnt++; if (rc !== 5) $display("FAIL lat3_sb_rsp got %0d want 5", rc); else pass_cnt++;
    issue(1'b1, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (rc !== 5 || rd !== 32'h889955BB) $display("FAIL lat3_lw cyc=%0d rdata=%h want 5/889955bb", rc, rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b0, 32'h11, SZ_B, 1'b1, 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (rc !== 3 || rd !== 32'h000000AA) $display("FAIL b2b_first cyc=%0d rdata=%h want 3/000000aa", rc, rd); else pass_cnt++;
    issue(1'b0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, rc, rd, er, wc, wy, wd, r0, q0, rb);
    total_cnt++; if (r0 !== 1'b1 || q0 !== 1'b0) $display("FAIL b2b_accept ready=%0b rsp_valid=%0b want 1/0", r0, q0); else pass_cnt++;
    total_cnt++; if (rc !== 3 || rd !== 32'h8899AABB) $display("FAIL b2b_second cyc=%0d rdata=%h want 3/8899aabb", rc, rd); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; cur_sel = 1'b0;
    t_we = 1'b0; t_addr = '0; t_size = 2'b00; t_uns = 1'b0; t_wdata = '0;
    pl_en0 = 1'b0; pl_en1 = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_load();
    test_store_sub();
    test_store_word();
    test_errors();
    test_reset_abort();
    test_latency3();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
